// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: shared constants for the parametrised APB timer.
//   Register byte addresses, TCR/TSR bit positions and the set of
//   implemented status bits. Optional compare feature: TMR_COMPARE_EN.
package apb_timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h04;
  localparam logic [7:0] ADDR_TSR  = 8'h08;
  localparam logic [7:0] ADDR_TCNT = 8'h0C;
  localparam logic [7:0] ADDR_TIER = 8'h10;
  localparam logic [7:0] ADDR_TCMP = 8'h14;

  localparam int TCR_LOAD    = 7;
  localparam int TCR_RELOAD  = 6;
  localparam int TCR_DW      = 5;
  localparam int TCR_EN      = 4;
  localparam int TCR_CKS_MSB = 2;
  localparam int TCR_CKS_LSB = 0;

  // Bit 3 of TCR is reserved and never stored.
  localparam logic [7:0] TCR_MASK = 8'hF7;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;
  localparam int TSR_CMP = 2;

`ifdef TMR_COMPARE_EN
  localparam bit         CMP_EN   = 1'b1;
  localparam logic [2:0] TSR_MASK = 3'b111;
`else
  localparam bit         CMP_EN   = 1'b0;
  localparam logic [2:0] TSR_MASK = 3'b011;
`endif

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running divider producing a one-cycle tick every
//   2^(cks+1) pclk cycles (cks 0..7 -> /2../256).
// Ports:
//   pclk, presetn : clock, async active-low reset
//   en            : run enable; divider held at 0 while low
//   cks           : divide select
//   clr           : synchronous restart (TCR write)
//   tick          : one-cycle pulse
module timer_prescaler (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       en,
  input  logic [2:0] cks,
  input  logic       clr,
  output logic       tick
);

  logic [7:0] div_q, div_d, mask;

  // Low cks+1 bits all ones marks the last cycle of a period.
  assign mask  = 8'hFF >> (3'd7 - cks);
  assign tick  = en & ~clr & ((div_q & mask) == mask);
  assign div_d = (clr | ~en) ? 8'd0 : div_q + 8'd1;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) div_q <= '0;
    else          div_q <= div_d;
  end

endmodule

// File: rtl/apb_timer_param.sv
// apb_timer_param: APB slave timer with configurable counter width,
//   8-step prescaler, load/auto-reload, up/down count, W1C status flags,
//   interrupt enables and a registered level irq.
// Optional compare register/flag compiled in with macro TMR_COMPARE_EN.
// Ports:
//   pclk, presetn              : clock, async active-low reset
//   psel, penable, pwrite      : APB control
//   paddr, pwdata              : APB address / write data
//   prdata, pready, pslverr    : APB response (zero wait states)
//   irq                        : level interrupt, |(TSR & TIER) registered
module apb_timer_param
  import apb_timer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PDATA_W = 32,
  parameter int PADDR_W = 8
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [PADDR_W-1:0] paddr,
  input  logic [PDATA_W-1:0] pwdata,
  output logic [PDATA_W-1:0] prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               irq
);

  logic acc, wr, mapped;
  logic sel_tdr, sel_tcr, sel_tsr, sel_tcnt, sel_tier, sel_tcmp;

  logic [CNT_W-1:0] tdr_q, tdr_d, cnt_q, cnt_d;
  logic [7:0]       tcr_q, tcr_d;
  logic [2:0]       tsr_q, tsr_d, tier_q, tier_d, tsr_set, w1c;
  logic             irq_q, irq_d, tick;
  logic [PDATA_W-1:0] rdata;
  logic             unused_wdata;

`ifdef TMR_COMPARE_EN
  logic [CNT_W-1:0] tcmp_q, tcmp_d;
`endif

  assign unused_wdata = ^pwdata;

  assign acc      = psel & penable;
  assign sel_tdr  = (paddr == PADDR_W'(ADDR_TDR));
  assign sel_tcr  = (paddr == PADDR_W'(ADDR_TCR));
  assign sel_tsr  = (paddr == PADDR_W'(ADDR_TSR));
  assign sel_tcnt = (paddr == PADDR_W'(ADDR_TCNT));
  assign sel_tier = (paddr == PADDR_W'(ADDR_TIER));
  assign sel_tcmp = CMP_EN && (paddr == PADDR_W'(ADDR_TCMP));
  assign mapped   = sel_tdr | sel_tcr | sel_tsr | sel_tcnt | sel_tier | sel_tcmp;
  assign wr       = acc & pwrite & mapped;

  timer_prescaler u_presc (
    .pclk    (pclk),
    .presetn (presetn),
    .en      (tcr_q[TCR_EN]),
    .cks     (tcr_q[TCR_CKS_MSB:TCR_CKS_LSB]),
    .clr     (wr & sel_tcr),
    .tick    (tick)
  );

  always_comb begin
    tdr_d   = tdr_q;
    tcr_d   = tcr_q;
    tier_d  = tier_q;
    cnt_d   = cnt_q;
    tsr_set = '0;
    w1c     = '0;
    if (wr && sel_tdr)  tdr_d  = pwdata[CNT_W-1:0];
    if (wr && sel_tcr)  tcr_d  = pwdata[7:0] & TCR_MASK;
    if (wr && sel_tier) tier_d = pwdata[2:0] & TSR_MASK;
    if (wr && sel_tsr)  w1c    = pwdata[2:0];

    if (tcr_q[TCR_LOAD]) begin
      cnt_d = tdr_q;
    end else if (tick) begin
      if (tcr_q[TCR_DW]) begin
        if (cnt_q == '0) begin
          tsr_set[TSR_UDF] = 1'b1;
          cnt_d = tcr_q[TCR_RELOAD] ? tdr_q : '1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else begin
        if (cnt_q == '1) begin
          tsr_set[TSR_OVF] = 1'b1;
          cnt_d = tcr_q[TCR_RELOAD] ? tdr_q : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef TMR_COMPARE_EN
      if (cnt_d == tcmp_q) tsr_set[TSR_CMP] = 1'b1;
`endif
    end

    // A flag being set wins over a same-cycle W1C.
    tsr_d = ((tsr_q & ~w1c) | tsr_set) & TSR_MASK;
    irq_d = |(tsr_q & tier_q);
  end

`ifdef TMR_COMPARE_EN
  always_comb begin
    tcmp_d = tcmp_q;
    if (wr && sel_tcmp) tcmp_d = pwdata[CNT_W-1:0];
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) tcmp_q <= '0;
    else          tcmp_q <= tcmp_d;
  end
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr_q  <= '0;
      tcr_q  <= '0;
      tsr_q  <= '0;
      tier_q <= '0;
      cnt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      tdr_q  <= tdr_d;
      tcr_q  <= tcr_d;
      tsr_q  <= tsr_d;
      tier_q <= tier_d;
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (acc) begin
      if (sel_tdr)  rdata[CNT_W-1:0] = tdr_q;
      if (sel_tcr)  rdata[7:0]       = tcr_q;
      if (sel_tsr)  rdata[2:0]       = tsr_q;
      if (sel_tcnt) rdata[CNT_W-1:0] = cnt_q;
      if (sel_tier) rdata[2:0]       = tier_q;
`ifdef TMR_COMPARE_EN
      if (sel_tcmp) rdata[CNT_W-1:0] = tcmp_q;
`endif
    end
  end

  assign prdata  = rdata;
  assign pready  = acc;
  assign pslverr = acc & ~mapped;
  assign irq     = irq_q;

endmodule

// File: tb/tb_apb_timer_param.sv
module tb_apb_timer_param;
  import apb_timer_pkg::*;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel8, psel16, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata8, prdata16;
  logic        pready8, pready16, pslverr8, pslverr16, irq8, irq16;

  int cyc = 0;
  int t0  = 0;
  int n_chk = 0;
  int n_err = 0;

  apb_timer_param #(.CNT_W(8)) u_dut8 (
    .pclk(pclk), .presetn(presetn), .psel(psel8), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata8),
    .pready(pready8), .pslverr(pslverr8), .irq(irq8)
  );

  apb_timer_param #(.CNT_W(16)) u_dut16 (
    .pclk(pclk), .presetn(presetn), .psel(psel16), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata16),
    .pready(pready16), .pslverr(pslverr16), .irq(irq16)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Commit on the posedge ending the access phase; returns just after it.
  task automatic apb_wr(input bit d8, input logic [7:0] a, input logic [31:0] d,
                        output logic err);
    @(negedge pclk);
    psel8 = d8; psel16 = ~d8; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1 err = d8 ? pslverr8 : pslverr16;
    @(posedge pclk);
    #1 psel8 = 1'b0; psel16 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic w(input bit d8, input logic [7:0] a, input logic [31:0] d);
    logic e;
    apb_wr(d8, a, d, e);
  endtask

  task automatic apb_rd(input bit d8, input logic [7:0] a, output logic [31:0] d,
                        output logic err, output logic rdy);
    @(negedge pclk);
    psel8 = d8; psel16 = ~d8; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    d   = d8 ? prdata8   : prdata16;
    err = d8 ? pslverr8  : pslverr16;
    rdy = d8 ? pready8   : pready16;
    @(posedge pclk);
    #1 psel8 = 1'b0; psel16 = 1'b0; penable = 1'b0;
  endtask

  // Advance to just after posedge number k counted from mark t0.
  task automatic wait_to(input int k);
    while (cyc - t0 < k) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Read whose data reflects state just after posedge k (k=0: read now).
  task automatic rchk(input bit d8, input int k, input logic [7:0] a,
                      input logic [31:0] exp, input string tag);
    logic [31:0] d;
    logic e, r;
    if (k > 0) wait_to(k - 1);
    apb_rd(d8, a, d, e, r);
    chk(tag, d, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic e, r;
    psel8 = 0; psel16 = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_irq8", {31'd0, irq8}, 32'd0);
    chk("rst_irq16", {31'd0, irq16}, 32'd0);
    chk("rst_prdata16", prdata16, 32'd0);
    chk("rst_slverr16", {31'd0, pslverr16}, 32'd0);
    presetn = 1'b1;
    t0 = cyc;
    rchk(0, 0, ADDR_TCNT, 32'h0, "rst_tcnt16");
    rchk(0, 0, ADDR_TCR,  32'h0, "rst_tcr16");
    rchk(1, 0, ADDR_TSR,  32'h0, "rst_tsr8");

    // bus errors / register access
    apb_rd(0, 8'h18, d, e, r);
    chk("unmapped_slverr", {31'd0, e}, 32'd1);
    chk("unmapped_data", d, 32'd0);
    chk("unmapped_pready", {31'd0, r}, 32'd1);
    apb_wr(0, ADDR_TCNT, 32'h1234, e);
    chk("tcnt_wr_slverr", {31'd0, e}, 32'd0);
    rchk(0, 0, ADDR_TCNT, 32'h0, "tcnt_ro");
    w(0, ADDR_TCR, 32'h0F);
    rchk(0, 0, ADDR_TCR, 32'h07, "tcr_rsvd_bit3");
    w(0, ADDR_TCR, 32'h00);
    w(0, ADDR_TIER, 32'h07);
`ifdef TMR_COMPARE_EN
    rchk(0, 0, ADDR_TIER, 32'h07, "tier_bits");
    w(0, ADDR_TCMP, 32'hABCD);
    rchk(0, 0, ADDR_TCMP, 32'hABCD, "tcmp_rw");
`else
    rchk(0, 0, ADDR_TIER, 32'h03, "tier_bits");
    apb_rd(0, 8'h14, d, e, r);
    chk("tcmp_unmapped_slverr", {31'd0, e}, 32'd1);
`endif
    w(0, ADDR_TIER, 32'h00);

    // legacy 8-bit: load 0xFF, count down /8, 256 ticks -> underflow to 0xFF
    w(1, ADDR_TDR, 32'hFF);
    w(1, ADDR_TCR, 32'h82);
    w(1, ADDR_TCR, 32'h32);
    t0 = cyc;
    rchk(1, 2048, ADDR_TSR,  32'h02, "leg_tsr_udf");
    rchk(1, 2050, ADDR_TCNT, 32'hFF, "leg_tcnt");

    // auto-reload up, /2: 16th tick (posedge 32) overflows and reloads
    w(0, ADDR_TDR, 32'hFFF0);
    w(0, ADDR_TCR, 32'h80);
    w(0, ADDR_TCR, 32'h50);
    t0 = cyc;
    rchk(0, 32, ADDR_TCNT, 32'hFFF0, "arl_tcnt_reload");
    rchk(0, 34, ADDR_TSR,  32'h01,   "arl_tsr_ovf");
    rchk(0, 36, ADDR_TCNT, 32'hFFF2, "arl_tcnt_plus2");

    // W1C and irq; next overflows at posedge 64 and 96
    w(0, ADDR_TSR, 32'h01);
    w(0, ADDR_TIER, 32'h01);
    rchk(0, 44, ADDR_TSR, 32'h00, "w1c_clear");
    wait_to(64);
    chk("irq_lags_flag", {31'd0, irq16}, 32'd0);
    wait_to(65);
    chk("irq_set", {31'd0, irq16}, 32'd1);
    w(0, ADDR_TSR, 32'h01);
    wait_to(68);
    chk("irq_clear", {31'd0, irq16}, 32'd0);
    rchk(0, 70, ADDR_TSR, 32'h00, "w1c_clear2");
    wait_to(94);
    w(0, ADDR_TSR, 32'h01);
    rchk(0, 98, ADDR_TSR, 32'h01, "set_wins_clear");

    // async reset mid-count
    w(1, ADDR_TDR, 32'h00);
    w(1, ADDR_TCR, 32'h80);
    w(1, ADDR_TCR, 32'h17);
    t0 = cyc;
    rchk(1, 600, ADDR_TCNT, 32'h02, "cks7_count");
    chk("irq_before_rst", {31'd0, irq16}, 32'd1);
    @(negedge pclk);
    presetn = 1'b0;
    #1 chk("rst_irq_async", {31'd0, irq16}, 32'd0);
    rchk(1, 0, ADDR_TCNT, 32'h0, "rst_tcnt_mid");
    rchk(1, 0, ADDR_TCR,  32'h0, "rst_tcr_mid");
    @(negedge pclk);
    presetn = 1'b1;
    t0 = cyc;
    rchk(1, 300, ADDR_TCNT, 32'h0, "no_count_after_rst");

`ifdef TMR_COMPARE_EN
    // compare: up from 0 at /4, 5th tick at posedge 20 hits TCMP=5
    w(1, ADDR_TCMP, 32'h05);
    w(1, ADDR_TCR, 32'h11);
    t0 = cyc;
    rchk(1, 18, ADDR_TSR, 32'h00, "cmp_not_yet");
    rchk(1, 20, ADDR_TSR, 32'h04, "cmp_set");
`else
    apb_wr(1, ADDR_TCMP, 32'h05, e);
    chk("tcmp_wr_slverr", {31'd0, e}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/apb_timer_param.md
Name: apb_timer_param

Overview:
- Parametrised APB timer; next generation of the 8-bit up/down timer.
- Counter width is configurable (CNT_W) and the prescaler has 8 settings.
- Adds auto-reload, a readable live count, interrupt enable and a level irq output.
- Sits on the APB peripheral bus as a slave, driven by the CPU bus model in benches.

Parameters:
- CNT_W, 16, counter/TDR width; legal range 8..32.
- PDATA_W, 32, APB data width; must be >= CNT_W.
- PADDR_W, 8, APB address width.

Ports:
- pclk  in  1  system/APB clock.
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  PADDR_W  byte address.
- pwdata  in  PDATA_W  write data.
- prdata  out  PDATA_W  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  error response.
- irq  out  1  level interrupt.

Behaviour:
- Reset is asynchronous on presetn low. All registers, the prescaler and the counter clear to 0; prdata=0, pslverr=0, irq=0.
- APB timing: zero wait states. pready=1 whenever psel&penable. Write commits on the pclk edge ending the access phase. prdata is combinational from paddr during the access phase and 0 otherwise.
- pslverr=1 in the access phase for an unmapped address; that write is ignored and prdata=0.
- Register map (unused high bits read 0):
  - 0x00 TDR, RW, [CNT_W-1:0], load/reload value.
  - 0x04 TCR, RW. Bit 7 load, bit 6 reload (auto-reload), bit 5 dw (1 = down), bit 4 en, bits 2:0 cks; bit 3 reserved, reads 0.
  - 0x08 TSR, R/W1C. Bit 0 ovf, bit 1 udf, bit 2 cmp (when the optional feature is compiled in).
  - 0x0C TCNT, RO, live counter value; writes are ignored with no error.
  - 0x10 TIER, RW, per-bit enables aligned with TSR.
  - 0x14 TCMP, RW, only when the optional feature is compiled in.
- Prescaler:
  - Free-running counter that emits a tick every 2^(cks+1) pclk, so cks=0..7 gives /2../256; cks 0..3 match the legacy clk2/4/8/16.
  - Cleared while en=0 and on any TCR write.
- Counter, in priority order each pclk:
  1. load=1: cnt<=TDR; no counting while load stays 1.
  2. en=1 and tick: cnt<=cnt±1.
  3. Otherwise hold.
- Wrap and flags:
  - Up from all-ones: ovf set; cnt<=TDR if reload=1, else 0.
  - Down from 0: udf set; cnt<=TDR if reload=1, else all-ones.
  - Flags are set in the same cycle as the wrap edge.
- Flag clear: writing 1 clears a flag. If a set and a clear hit the same cycle, the set wins.
- irq = |(TSR & TIER), registered; asserts 1 pclk after the flag.
- Changing dw mid-count takes effect on the next tick; there is no reload.
- Reset asserted mid-count clears everything immediately; no pending tick survives.

Optional Feature:
- Macro TMR_COMPARE_EN.
- Defined:
  - Adds TCMP at 0x14.
  - TSR bit 2 cmp is set on the tick that makes cnt==TCMP.
  - TIER bit 2 enables it onto irq.
- Undefined:
  - 0x14 is unmapped and gives pslverr.
  - TSR/TIER bit 2 read 0.

Decomposition:
- Package apb_timer_pkg holds:
  - Address constants ADDR_TDR..ADDR_TCMP.
  - TCR bit indices (LOAD, RELOAD, DW, EN, CKS_LSB/MSB).
  - TSR bit indices.
- One sub-module, timer_prescaler:
  - Inputs: pclk, presetn, en, cks, clr.
  - Output: tick.

Test Plan:
- Legacy (CNT_W=8): TDR=0xFF, TCR=0x82, then TCR=0x32; wait 2048 pclk → read TSR=0x02, TCNT=0xFF (wrapped to all-ones).
- Auto-reload up: TDR=0xFFF0, TCR=0x80, then TCR=0x50 (cks=0); wait 32 pclk → TSR=0x01, TCNT=0xFFF0, 2 further ticks → TCNT=0xFFF2.
- W1C and irq: set TIER=0x01, reach overflow → irq=1 one pclk after ovf; write TSR=0x01 → TSR=0x00 and irq=0 next cycle; force clear and set in the same cycle → ovf stays 1.
- Bus errors: read 0x18 → pslverr=1, prdata=0; write TCNT=0x1234 → TCNT unchanged, pslverr=0.
- Async reset mid-count: counting at cks=7, drop presetn for 3 pclk → TCNT=0, TCR=0, irq=0 immediately; no count until re-enabled.
- TMR_COMPARE_EN: TDR=0, TCMP=0x0005, TCR up with cks=1; after 5 ticks (20 pclk) → TSR=0x04.
